// File: rtl/grid_map_arbiter_pkg.sv
// ============================================================================
// Module : astar_grid_pkg
// Brief  : Shared grid geometry, cell codes and address helper for the map.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package astar_grid_pkg;

  localparam int GRID_W    = 40;
  localparam int GRID_H    = 40;
  localparam int CELL_W    = 2;
  localparam int COORD_W   = 8;
  localparam int MAP_DEPTH = GRID_W * GRID_H;
  localparam int ADDR_W    = 11;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAP_DEPTH - 1);

  typedef enum logic [CELL_W-1:0] {
    FREE     = 2'b00,
    OBSTACLE = 2'b01,
    PATH     = 2'b10,
    UNKNOWN  = 2'b11
  } cell_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Where a registered read response takes its data from.
  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_OBST = 2'd1,
    SRC_UNKN = 2'd2
  } src_t;

  // Row-major address y*40 + x built from shifts.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] xx;
    logic [ADDR_W-1:0] yy;
    xx = ADDR_W'(x);
    yy = ADDR_W'(y);
    return (yy << 5) + (yy << 3) + xx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_map_arbiter_ram.sv
// ============================================================================
// Module : grid_cell_ram
// Brief  : Single-port cell map storage, synchronous write, registered read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module grid_cell_ram
  import astar_grid_pkg::*;
#(
  parameter int DEPTH = MAP_DEPTH,
  parameter int WIDTH = CELL_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/grid_map_arbiter.sv
// ============================================================================
// Module : grid_map_arbiter
// Brief  : Shares the 40x40 cell map between display (priority) and search.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module grid_map_arbiter
  import astar_grid_pkg::*;
#(
  parameter int GRID_W  = astar_grid_pkg::GRID_W,
  parameter int GRID_H  = astar_grid_pkg::GRID_H,
  parameter int CELL_W  = astar_grid_pkg::CELL_W,
  parameter int COORD_W = astar_grid_pkg::COORD_W
) (
  input  logic               sync,
  input  logic               reset,
  input  logic               clr_start,
  output logic               clr_busy,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  output logic [CELL_W-1:0]  disp_rdata,
  output logic               disp_rvalid,
  input  logic               srch_valid,
  output logic               srch_ready,
  input  logic               srch_we,
  input  logic [COORD_W-1:0] srch_x,
  input  logic [COORD_W-1:0] srch_y,
  input  logic [CELL_W-1:0]  srch_wdata,
  output logic [CELL_W-1:0]  srch_rdata,
  output logic               srch_rvalid,
  output logic               err_oob
);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
  logic                w_disp_in, w_srch_in, w_accept;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [CELL_W-1:0]   w_ram_wdata, w_ram_rdata;
  src_t                r_disp_src;
  logic                r_srch_oob;
  logic [CELL_W-1:0]   r_disp_hold, r_srch_hold;

  assign w_disp_in  = (disp_x < COORD_W'(GRID_W)) && (disp_y < COORD_W'(GRID_H));
  assign w_srch_in  = (srch_x < COORD_W'(GRID_W)) && (srch_y < COORD_W'(GRID_H));
  assign clr_busy   = (r_state == ST_CLEAR);
  assign srch_ready = (r_state == ST_SERVE) && !disp_req;
  assign w_accept   = srch_valid && srch_ready;

  always_ff @(posedge sync) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (clr_start) begin
          w_clr_cnt_nxt = '0;
        end else if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = ST_SERVE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        end
      end
      default: begin
        if (clr_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Single RAM port: clear sweep, else display, else search.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_clr_cnt;
    w_ram_wdata = FREE;
    if (r_state == ST_CLEAR) begin
      w_ram_we = 1'b1;
    end else if (disp_req) begin
      w_ram_addr = cell_addr(disp_x, disp_y);
    end else begin
      w_ram_addr  = cell_addr(srch_x, srch_y);
      w_ram_we    = w_accept && srch_we && w_srch_in;
      w_ram_wdata = srch_wdata;
    end
  end

  grid_cell_ram #(
    .DEPTH (MAP_DEPTH),
    .WIDTH (CELL_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (sync),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge sync) begin
    if (reset) begin
      disp_rvalid <= 1'b0;
      r_disp_src  <= SRC_RAM;
      srch_rvalid <= 1'b0;
      r_srch_oob  <= 1'b0;
      err_oob     <= 1'b0;
      r_disp_hold <= '0;
      r_srch_hold <= '0;
    end else begin
      disp_rvalid <= disp_req;
      if (disp_req) begin
        r_disp_src <= (r_state == ST_CLEAR) ? SRC_UNKN :
                      (w_disp_in ? SRC_RAM : SRC_OBST);
      end
      srch_rvalid <= w_accept && !srch_we;
      if (w_accept) begin
        r_srch_oob <= !w_srch_in;
      end
      err_oob <= w_accept && !w_srch_in;
      if (disp_rvalid) begin
        r_disp_hold <= disp_rdata;
      end
      if (srch_rvalid) begin
        r_srch_hold <= srch_rdata;
      end
    end
  end

  // Responses are steered from the RAM output in the cycle after the request.
  always_comb begin
    disp_rdata = r_disp_hold;
    if (disp_rvalid) begin
      case (r_disp_src)
        SRC_RAM:  disp_rdata = w_ram_rdata;
        SRC_OBST: disp_rdata = OBSTACLE;
        default:  disp_rdata = UNKNOWN;
      endcase
    end
  end

  always_comb begin
    srch_rdata = r_srch_hold;
    if (srch_rvalid) begin
      srch_rdata = r_srch_oob ? CELL_W'(OBSTACLE) : w_ram_rdata;
    end
  end

endmodule

`default_nettype wire
